// File: rtl/riscv_pkg.sv
// Shared fetch-side types: IF/ID bubble word, fetch FSM states and the IF/ID record.
package riscv_pkg;

  localparam int unsigned PC_W = 9;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush to bubble beats load; otherwise hold.
module ifid_reg
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic                flush_i,
  input  logic [PC_W-1:0]     pc_i,
  input  logic [31:0]         instr_i,
  output ifid_t               ifid_o
);

  ifid_t ifid_q;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      ifid_q <= IFID_BUBBLE;
    end else if (load_i) begin
      ifid_q <= '{pc: pc_i, instr: instr_i, valid: 1'b1};
    end
  end

  assign ifid_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, halt FSM, IF/ID capture
// and a count of instructions delivered to decode.
module fetch_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              pc_sel_i,
  input  logic [31:0]       br_pc_i,
  input  logic              halt_i,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  output logic [PC_W-1:0]   ifid_pc_o,
  output logic [31:0]       ifid_instr_o,
  output logic              ifid_valid_o,
  output logic              redirect_o,
  output logic              halted_o,
  output logic [31:0]       fetch_count_o
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     count_q, count_d;
  logic            ifid_load, ifid_flush;
  logic [PC_W-1:0] br_target;
  ifid_t           ifid;

  // Targets are word-aligned and truncated to the PC width; the dropped bits are ignored.
  assign br_target = {br_pc_i[PC_W-1:2], 2'b00};

  logic unused_br_bits;
  assign unused_br_bits = ^{br_pc_i[31:PC_W], br_pc_i[1:0]};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (state_q == ST_RUN) begin
      if (pc_sel_i) begin
        // A redirect beats a stall so the wrong-path word cannot linger in IF/ID.
        pc_d       = br_target;
        ifid_flush = 1'b1;
        if (halt_i) begin
          state_d = ST_HALTED;
        end
      end else if (!stall_i) begin
        pc_d      = pc_q + PC_W'(4);
        ifid_load = 1'b1;
        count_d   = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .pc_i    (pc_q),
    .instr_i (imem_rdata_i),
    .ifid_o  (ifid)
  );

  assign imem_addr_o   = pc_q;
  assign ifid_pc_o     = ifid.pc;
  assign ifid_instr_o  = ifid.instr;
  assign ifid_valid_o  = ifid.valid;
  assign redirect_o    = pc_sel_i & (state_q == ST_RUN) & ~reset;
  assign halted_o      = (state_q == ST_HALTED);
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected fetches go into a queue and a monitor
// compares them whenever the DUT delivers a new instruction to IF/ID.
module tb_fetch_stage;

  localparam int PC_W = 9;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall_i;
  logic            pc_sel_i;
  logic [31:0]     br_pc_i;
  logic            halt_i;
  logic [PC_W-1:0] imem_addr_o;
  logic [31:0]     imem_rdata_i;
  logic [PC_W-1:0] ifid_pc_o;
  logic [31:0]     ifid_instr_o;
  logic            ifid_valid_o;
  logic            redirect_o;
  logic            halted_o;
  logic [31:0]     fetch_count_o;

  always #5 clk = ~clk;

  // Address-tagged instruction memory.
  assign imem_rdata_i = 32'hC0DE_0000 | {23'd0, imem_addr_o};

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .pc_sel_i      (pc_sel_i),
    .br_pc_i       (br_pc_i),
    .halt_i        (halt_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_instr_o  (ifid_instr_o),
    .ifid_valid_o  (ifid_valid_o),
    .redirect_o    (redirect_o),
    .halted_o      (halted_o),
    .fetch_count_o (fetch_count_o)
  );

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_exp_t;

  fetch_exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expect_fetch(input logic [PC_W-1:0] pc, input logic [31:0] instr);
    exp_q.push_back('{pc: pc, instr: instr});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a change of fetch_count_o outside reset marks a new IF/ID delivery.
  logic [31:0] last_count = 32'd0;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      last_count = fetch_count_o;
    end else if (fetch_count_o !== last_count) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_fetch: got ifid_pc 0x%03h count %0d expected no fetch",
                 ifid_pc_o, fetch_count_o);
      end else begin
        fetch_exp_t e;
        e = exp_q.pop_front();
        check("mon_ifid_pc", 32'(ifid_pc_o), 32'(e.pc));
        check("mon_ifid_instr", ifid_instr_o, e.instr);
        check("mon_ifid_valid", 32'(ifid_valid_o), 32'd1);
        check("mon_count_step", fetch_count_o, last_count + 32'd1);
      end
      last_count = fetch_count_o;
    end
  end

  initial begin
    reset = 1'b1; stall_i = 1'b0; pc_sel_i = 1'b0; br_pc_i = '0; halt_i = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state.
    check("rst_pc", 32'(imem_addr_o), 32'h0);
    check("rst_ifid_valid", 32'(ifid_valid_o), 32'd0);
    check("rst_ifid_instr", ifid_instr_o, NOP);
    check("rst_ifid_pc", 32'(ifid_pc_o), 32'h0);
    check("rst_count", fetch_count_o, 32'd0);
    check("rst_halted", 32'(halted_o), 32'd0);
    check("rst_redirect", 32'(redirect_o), 32'd0);

    // Free-running fetch of 0, 4, 8.
    expect_fetch(9'h000, 32'hC0DE_0000);
    expect_fetch(9'h004, 32'hC0DE_0004);
    expect_fetch(9'h008, 32'hC0DE_0008);
    step(); step(); step();
    check("run_imem_addr", 32'(imem_addr_o), 32'h00C);
    check("run_count", fetch_count_o, 32'd3);

    // Stall two cycles: everything holds.
    stall_i = 1'b1;
    step(); step();
    check("stall_pc", 32'(imem_addr_o), 32'h00C);
    check("stall_ifid_pc", 32'(ifid_pc_o), 32'h008);
    check("stall_ifid_instr", ifid_instr_o, 32'hC0DE_0008);
    check("stall_ifid_valid", 32'(ifid_valid_o), 32'd1);
    check("stall_count", fetch_count_o, 32'd3);
    stall_i = 1'b0;
    expect_fetch(9'h00C, 32'hC0DE_000C);
    step();
    check("resume_pc", 32'(imem_addr_o), 32'h010);

    // Redirect at pc 0x10 to 0x40: one bubble, then the target.
    pc_sel_i = 1'b1; br_pc_i = 32'h0000_0040;
    #1 check("redirect_o_run", 32'(redirect_o), 32'd1);
    step();
    pc_sel_i = 1'b0;
    check("redir_pc", 32'(imem_addr_o), 32'h040);
    check("redir_valid", 32'(ifid_valid_o), 32'd0);
    check("redir_instr", ifid_instr_o, NOP);
    check("redir_count", fetch_count_o, 32'd4);
    expect_fetch(9'h040, 32'hC0DE_0040);
    step();
    check("after_redir_pc", 32'(imem_addr_o), 32'h044);

    // Redirect and stall together: redirect wins.
    pc_sel_i = 1'b1; stall_i = 1'b1; br_pc_i = 32'h0000_0080;
    step();
    stall_i = 1'b0;
    check("redir_stall_pc", 32'(imem_addr_o), 32'h080);
    check("redir_stall_valid", 32'(ifid_valid_o), 32'd0);

    // Back-to-back redirects.
    br_pc_i = 32'h0000_0100;
    step();
    br_pc_i = 32'h0000_0104;
    step();
    check("b2b_pc", 32'(imem_addr_o), 32'h104);
    check("b2b_valid", 32'(ifid_valid_o), 32'd0);
    check("b2b_count", fetch_count_o, 32'd5);

    // PC wrap at the top of the 9-bit space.
    br_pc_i = 32'h0000_01FC;
    step();
    pc_sel_i = 1'b0;
    check("wrap_start_pc", 32'(imem_addr_o), 32'h1FC);
    expect_fetch(9'h1FC, 32'hC0DE_01FC);
    step();
    check("wrap_pc", 32'(imem_addr_o), 32'h000);
    expect_fetch(9'h000, 32'hC0DE_0000);
    step();
    check("wrap_count", fetch_count_o, 32'd7);

    // Target truncation and alignment.
    pc_sel_i = 1'b1; br_pc_i = 32'h0000_0203;
    step();
    check("trunc_align_pc", 32'(imem_addr_o), 32'h000);
    br_pc_i = 32'hFFFF_FE4A;
    step();
    check("trunc_hi_pc", 32'(imem_addr_o), 32'h048);
    check("trunc_count", fetch_count_o, 32'd7);

    // Halt: sticky, frozen, ignores everything.
    halt_i = 1'b1; br_pc_i = 32'h0000_0024;
    step();
    check("halt_halted", 32'(halted_o), 32'd1);
    check("halt_pc", 32'(imem_addr_o), 32'h024);
    check("halt_valid", 32'(ifid_valid_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      pc_sel_i = i[0];
      stall_i  = i[1];
      halt_i   = i[2];
      br_pc_i  = 32'h0000_0100 + 32'(i * 4);
      #1 check("halted_redirect_o", 32'(redirect_o), 32'd0);
      step();
    end
    check("halted_pc_held", 32'(imem_addr_o), 32'h024);
    check("halted_sticky", 32'(halted_o), 32'd1);
    check("halted_count", fetch_count_o, 32'd7);
    check("halted_ifid_valid", 32'(ifid_valid_o), 32'd0);

    // Reset leaves HALTED and overrides a simultaneous redirect.
    reset = 1'b1; pc_sel_i = 1'b1; halt_i = 1'b0; stall_i = 1'b0;
    #1 check("reset_masks_redirect", 32'(redirect_o), 32'd0);
    step(); step();
    reset = 1'b0; pc_sel_i = 1'b0;
    check("post_rst_pc", 32'(imem_addr_o), 32'h0);
    check("post_rst_halted", 32'(halted_o), 32'd0);
    check("post_rst_count", fetch_count_o, 32'd0);
    check("post_rst_instr", ifid_instr_o, NOP);
    expect_fetch(9'h000, 32'hC0DE_0000);
    step();
    step();
    stall_i = 1'b1;
    expect_fetch(9'h004, 32'hC0DE_0004);
    step();
    check("pending_fetches", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
